// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: runs one command at a time (CLEAR, LOAD_EDGE, SWAP, STATUS); ports cmd_*, ew_*, edge_*, clr_*, vblank/fb_sel, tx_*
module gpu_cmd_sequencer #(
  parameter int EDGE_AW = 10,
  parameter int WORDS_PER_EDGE = 3
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_op,
  input  logic [7:0]         cmd_arg,
  input  logic [15:0]        cmd_addr,
  input  logic               ew_valid,
  output logic               ew_ready,
  input  logic [15:0]        ew_data,
  output logic               edge_we,
  output logic [EDGE_AW-1:0] edge_addr,
  output logic [15:0]        edge_wdata,
  output logic               clr_start,
  output logic [7:0]         clr_color,
  input  logic               clr_done,
  input  logic               vblank,
  output logic               fb_sel,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data
);
  localparam int CW = $clog2(255 * WORDS_PER_EDGE + 1);
  localparam logic [7:0] OP_SWAP = 8'h01, OP_CLEAR = 8'h02, OP_EDGE = 8'h05, OP_STAT = 8'h07;
  typedef enum logic [2:0] {IDLE, CLEAR, EDGE, SWAP, STAT} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [EDGE_AW-1:0] ptr;
  logic [5:0] swap_cnt;
  logic err, accept, ew_hs, known;
  assign cmd_ready = state == IDLE;
  assign ew_ready = state == EDGE;
  assign tx_valid = state == STAT;
  assign accept = cmd_valid && cmd_ready;
  assign ew_hs = ew_valid && ew_ready;
  assign known = cmd_op inside {OP_SWAP, OP_CLEAR, OP_EDGE, OP_STAT};
  always_ff @(posedge CLK or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (accept) next = cmd_op == OP_CLEAR ? CLEAR :
                               cmd_op == OP_EDGE && cmd_arg != 8'd0 ? EDGE :
                               cmd_op == OP_SWAP ? SWAP :
                               cmd_op == OP_STAT ? STAT : IDLE;
      CLEAR: if (clr_done) next = IDLE;
      EDGE:  if (ew_hs && cnt == CW'(1)) next = IDLE;
      SWAP:  if (vblank) next = IDLE;
      STAT:  if (tx_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      cnt <= '0;
      ptr <= '0;
      swap_cnt <= '0;
      err <= 1'b0;
      edge_we <= 1'b0;
      edge_addr <= '0;
      edge_wdata <= '0;
      clr_start <= 1'b0;
      clr_color <= '0;
      fb_sel <= 1'b0;
      tx_data <= '0;
    end else begin
      clr_start <= accept && cmd_op == OP_CLEAR;
      edge_we <= ew_hs;
      if (accept && cmd_op == OP_CLEAR) clr_color <= cmd_arg;
      if (accept && cmd_op == OP_EDGE) begin
        cnt <= CW'(cmd_arg) * CW'(WORDS_PER_EDGE);
        ptr <= EDGE_AW'(cmd_addr * 16'(WORDS_PER_EDGE));
      end
      if (accept && cmd_op == OP_STAT) tx_data <= {fb_sel, err, swap_cnt};
      if (accept && !known) err <= 1'b1;
      else if (tx_valid && tx_ready) err <= 1'b0;
      if (ew_hs) begin
        edge_addr <= ptr;
        edge_wdata <= ew_data;
        ptr <= ptr + EDGE_AW'(1);
        cnt <= cnt - CW'(1);
      end
      if (state == SWAP && vblank) begin
        fb_sel <= ~fb_sel;
        swap_cnt <= swap_cnt + 6'd1;
      end
    end
endmodule
